// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared constants and key index encoding for the keypad scan controller.
package keypad_scan_ctrl_pkg;

  localparam int unsigned KEY_ROWS    = 4;
  localparam int unsigned KEY_COLS    = 4;
  localparam int unsigned KEY_IDX_W   = 4;
  localparam int unsigned KEY_CODE_W  = 5;
  localparam int unsigned KEY_REL_BIT = 4;

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } col_e;

  typedef logic [KEY_IDX_W-1:0] key_idx_t;

  function automatic key_idx_t key_idx(input int unsigned row, input int unsigned col);
    return key_idx_t'(row * KEY_COLS + col);
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Generic synchronous FIFO; push while full is accepted only together with a pop.
module keypad_event_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [PTR_W:0]   cnt_q;
  logic             wr_en, rd_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + 1'b1;
      end
      if (rd_en) rd_q <= rd_q + 1'b1;
      if (wr_en && !rd_en)      cnt_q <= cnt_q + 1'b1;
      else if (rd_en && !wr_en) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner with per-frame matrix debounce and a key-event FIFO.
// Release events are built only when KEYPAD_RELEASE_EVENT_EN is defined.
module keypad_scan_ctrl
  import keypad_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 5000,
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [KEY_ROWS-1:0]            keypad_row,
  output logic [KEY_COLS-1:0]            keypad_col,
  output logic                           key_valid,
  output logic [KEY_CODE_W-1:0]          key_code,
  input  logic                           key_ready,
  output logic [KEY_ROWS*KEY_COLS-1:0]   key_state
);

  localparam int unsigned NKEYS   = KEY_ROWS * KEY_COLS;
  localparam int unsigned DWELL_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(DEBOUNCE_FRAMES);

  logic [KEY_ROWS-1:0]   row_meta_q, row_sync_q;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  col_e                  col_q, col_d;
  logic [NKEYS-1:0]      snap_q, snap_d, prev_q, prev_d, state_q, state_d;
  logic [NKEYS-1:0]      press_q, press_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_dwell, frame_end, commit;

  logic                  fifo_full, fifo_empty, pop, can_push, push, found, sel_rel;
  key_idx_t              sel_idx;
  logic [KEY_CODE_W-1:0] push_code, fifo_dout;

`ifdef KEYPAD_RELEASE_EVENT_EN
  logic [NKEYS-1:0]      rel_q, rel_d;
`endif

  // Scan, snapshot assembly and debounce counting.
  always_comb begin
    last_dwell = (dwell_q == DWELL_LAST);
    frame_end  = last_dwell && (col_q == COL3);
    dwell_d    = last_dwell ? '0 : dwell_q + 1'b1;
    col_d      = col_q;
    snap_d     = snap_q;
    if (last_dwell) begin
      case (col_q)
        COL0:    col_d = COL1;
        COL1:    col_d = COL2;
        COL2:    col_d = COL3;
        default: col_d = COL0;
      endcase
      for (int unsigned r = 0; r < KEY_ROWS; r++)
        snap_d[key_idx(r, col_q)] = ~row_sync_q[r];
    end
    prev_d = prev_q;
    cnt_d  = cnt_q;
    if (frame_end) begin
      prev_d = snap_d;
      if (snap_d == prev_q) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      else                  cnt_d = CNT_W'(1);
    end
    commit  = (cnt_q == CNT_MAX) && (prev_q != state_q);
    state_d = commit ? prev_q : state_q;
  end

  // Pending-event selection: lowest pending press first, then releases.
  always_comb begin
    pop      = !fifo_empty && key_ready;
    can_push = !fifo_full || pop;
    found    = 1'b0;
    sel_idx  = '0;
    sel_rel  = 1'b0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      if (!found && press_q[i]) begin
        found   = 1'b1;
        sel_idx = key_idx_t'(i);
      end
    end
`ifdef KEYPAD_RELEASE_EVENT_EN
    for (int unsigned i = 0; i < NKEYS; i++) begin
      if (!found && rel_q[i]) begin
        found   = 1'b1;
        sel_idx = key_idx_t'(i);
        sel_rel = 1'b1;
      end
    end
`endif
    push      = found && can_push;
    push_code = '0;
    push_code[KEY_IDX_W-1:0] = sel_idx;
    push_code[KEY_REL_BIT]   = sel_rel;

    press_d = press_q;
    if (push && !sel_rel) press_d[sel_idx] = 1'b0;
`ifdef KEYPAD_RELEASE_EVENT_EN
    rel_d = rel_q;
    if (push && sel_rel) rel_d[sel_idx] = 1'b0;
    // Unqueued presses survive their release so press precedes release.
    if (commit) begin
      press_d = press_d | (prev_q & ~state_q);
      rel_d   = rel_d | (~prev_q & state_q);
    end
`else
    if (commit) press_d = (press_d | (prev_q & ~state_q)) & prev_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      dwell_q    <= '0;
      col_q      <= COL0;
      snap_q     <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      state_q    <= '0;
      press_q    <= '0;
    end else begin
      row_meta_q <= keypad_row;
      row_sync_q <= row_meta_q;
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      snap_q     <= snap_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      press_q    <= press_d;
    end
  end

`ifdef KEYPAD_RELEASE_EVENT_EN
  always_ff @(posedge clk) begin
    if (rst) rel_q <= '0;
    else     rel_q <= rel_d;
  end
`endif

  keypad_event_fifo #(
    .WIDTH (KEY_CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_code),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign keypad_col = ~(4'b0001 << col_q);
  assign key_valid  = !fifo_empty;
  assign key_code   = fifo_dout;
  assign key_state  = state_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl with an ideal keypad matrix model.
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  keypad_row;
  logic [3:0]  keypad_col;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        key_ready = 1'b0;
  logic [15:0] key_state;
  logic [15:0] keys = '0;

  int compared   = 0;
  int mismatched = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (2),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .keypad_row (keypad_row),
    .keypad_col (keypad_col),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .key_state  (key_state)
  );

  always_comb begin
    keypad_row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!keypad_col[c] && keys[r*4+c]) keypad_row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL pop_unexpected: got %02h expected none", key_code);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check("pop_code", 32'(key_code), 32'(e));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string name, input logic [15:0] exp, input int budget);
    int n = 0;
    while (key_state !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(key_state), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    key_ready = 1'b1;
    while ((exp_q.size() != 0 || key_valid) && n < 100) begin
      step(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(6);
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_col", 32'(keypad_col), 32'h0000000E);
    check("rst_valid", 32'(key_valid), 0);
    check("rst_code", 32'(key_code), 0);
    check("rst_state", 32'(key_state), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("col_hold", 32'(keypad_col), 32'h0000000E);
    @(posedge clk);
    @(negedge clk);
    check("col_step", 32'(keypad_col), 32'h0000000D);
    @(posedge clk);
    #1;

    // single press of key 9 (row 2, col 1)
    keys[9] = 1'b1;
    exp_q.push_back(5'h09);
    wait_state("press9_state", 16'h0200, 64);
    step(2);
    check("press9_valid", 32'(key_valid), 1);
    check("press9_code", 32'(key_code), 32'h09);
    key_ready = 1'b1;
    step(1);
    check("press9_popped", 32'(key_valid), 0);
    keys[9] = 1'b0;
`ifdef KEYPAD_RELEASE_EVENT_EN
    exp_q.push_back(5'h19);
`endif
    wait_state("rel9_state", 16'h0000, 64);
    drain("drain_single");

    // bouncing key 9 must never commit
    for (int i = 0; i < 6; i++) begin
      keys[9] = ~keys[9];
      step(16);
      check("bounce_state", 32'(key_state), 0);
    end
    keys[9] = 1'b1;
    exp_q.push_back(5'h09);
    wait_state("bounce_hold_state", 16'h0200, 64);
    keys[9] = 1'b0;
`ifdef KEYPAD_RELEASE_EVENT_EN
    exp_q.push_back(5'h19);
`endif
    wait_state("bounce_rel_state", 16'h0000, 64);
    drain("drain_bounce");

    // four simultaneous presses fill the FIFO
    key_ready = 1'b0;
    keys = 16'h8421;
    exp_q.push_back(5'h00);
    exp_q.push_back(5'h05);
    exp_q.push_back(5'h0A);
    exp_q.push_back(5'h0F);
    wait_state("multi_state", 16'h8421, 64);
    step(6);
    check("full_valid", 32'(key_valid), 1);
    check("full_head", 32'(key_code), 32'h00);
    keys[3] = 1'b1;
    exp_q.push_back(5'h03);
    wait_state("key3_state", 16'h8429, 64);
    step(4);
    check("full_head_hold", 32'(key_code), 32'h00);
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    check("after_pop_head", 32'(key_code), 32'h05);
    step(2);

    // key 7 pressed and released while the FIFO stays full
    keys[7] = 1'b1;
    wait_state("key7_state", 16'h84A9, 64);
    step(2);
    keys[7] = 1'b0;
`ifdef KEYPAD_RELEASE_EVENT_EN
    exp_q.push_back(5'h07);
    exp_q.push_back(5'h17);
`endif
    wait_state("key7_rel_state", 16'h8429, 64);
    step(3);
    check("full_head_still", 32'(key_code), 32'h05);
    drain("drain_full");
    keys = '0;
`ifdef KEYPAD_RELEASE_EVENT_EN
    exp_q.push_back(5'h10);
    exp_q.push_back(5'h13);
    exp_q.push_back(5'h15);
    exp_q.push_back(5'h1A);
    exp_q.push_back(5'h1F);
`endif
    wait_state("all_rel_state", 16'h0000, 64);
    drain("drain_release_all");

    // key 12 press/release
    keys[12] = 1'b1;
    exp_q.push_back(5'h0C);
    wait_state("key12_state", 16'h1000, 64);
    keys[12] = 1'b0;
`ifdef KEYPAD_RELEASE_EVENT_EN
    exp_q.push_back(5'h1C);
`endif
    wait_state("key12_rel_state", 16'h0000, 64);
    drain("drain_key12");
    step(20);
    check("final_valid", 32'(key_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Scans the 4x4 matrix keypad on the board GPIO pins (keypad_col out, keypad_row in) and debounces the whole matrix per frame.
- Queues key-press events in a small FIFO behind a valid/ready interface.
- Sits between the keypad pins and the GPIO register block; the CPU-side register logic pops events and reads the stable key mask.

Parameters:
- SCAN_DIV, 5000: clock cycles each column is driven (dwell); must be >= 4.
- DEBOUNCE_FRAMES, 4: consecutive identical full-matrix snapshots needed to commit a new stable state; must be >= 1.
- FIFO_DEPTH, 8: event FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- keypad_row  in  4  row sense lines, active-low (pulled up; 0 = key closed in the driven column).
- keypad_col  out  4  column drive, active-low, exactly one bit low at any time.
- key_valid  out  1  FIFO non-empty.
- key_code  out  5  head event: [3:0] = row*4+col, [4] = release flag.
- key_ready  in  1  consumer pops the head when key_valid && key_ready.
- key_state  out  16  debounced stable mask, bit row*4+col = 1 while the key is held.

Behaviour:
- Reset values: keypad_col = 4'b1110, key_valid = 0, key_code = 0, key_state = 0. Internal state after reset: scan/dwell counters 0, debounce count 0, snapshot 0, pending masks 0, FIFO empty.
- Synchroniser: keypad_row passes through 2 flops, reset value 4'hF; all sampling uses the synchronised value.
- Column scan: dwell counter counts 0..SCAN_DIV-1. On the last dwell cycle:
  - capture inverted synced rows into snapshot bits {row*4+col};
  - advance col (0->1->2->3->0); keypad_col = ~(1<<col).
- Frame boundary: the last dwell cycle of col 3, i.e. every 4*SCAN_DIV cycles.
- Debounce, evaluated at each frame boundary:
  - assembled snapshot == previous-frame snapshot: debounce count increments, saturating at DEBOUNCE_FRAMES;
  - otherwise count resets to 1.
  - When the count reaches DEBOUNCE_FRAMES and snapshot != key_state, key_state <= snapshot on the following cycle.
- Event generation, on a key_state update:
  - press_pend |= new & ~old;
  - rel_pend |= ~new & old (release tracking only with the optional feature);
  - press_pend bits of keys no longer in key_state are cleared (a press released before being queued is discarded).
- Pusher: each cycle, if the FIFO is not full (or is full and popping this cycle), push the lowest-index pending press bit as code {0,idx}, then clear that bit.
  - Press bits take priority over release bits.
  - At most one push per cycle.
  - FIFO full: pending bits hold; nothing is lost while the key stays held.
- FIFO:
  - key_valid = !empty; key_code = head entry.
  - A push into an empty FIFO is visible the next cycle (latency 1).
  - Simultaneous push and pop is legal in any state, including full.
  - Pop on empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH; the count field is log2(FIFO_DEPTH)+1 bits.
- Multiple columns reading the same row (ghosting) are reported as-is; no ghost suppression.
- rst mid-scan or with a non-empty FIFO: all state returns to reset values on the next edge; queued events are discarded.

Optional Feature:
- Macro: KEYPAD_RELEASE_EVENT_EN.
- Defined: release transitions set rel_pend; the pusher emits {1,idx} after all pending presses are drained. A release whose press is still pending pushes the press first, then the release.
- Undefined: rel_pend logic is absent; key_code[4] is constant 0.

Decomposition:
- Shared package holds: KEY_ROWS = 4, KEY_COLS = 4, KEY_IDX_W = 4, KEY_CODE_W = 5, KEY_REL_BIT = 4, and the key_code encode rule (row*4+col).
- One natural sub-module: keypad_event_fifo, a generic synchronous FIFO with parameters WIDTH and DEPTH and ports push/din/full/pop/dout/empty.
- Scan, debounce and pending/priority logic stay in the top module.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=2, FIFO_DEPTH=4; frame = 16 cycles):
- Reset: assert rst for 3 cycles mid-scan -> keypad_col=4'b1110, key_valid=0, key_state=0 on the cycle after deassert; col steps to 4'b1101 after 4 cycles.
- Single press: hold row 2 low only while col 1 is driven (key 9) -> key_state[9]=1 within 3 frames (<=48 cycles + 3); key_valid=1 with key_code=5'h09; pop with key_ready -> key_valid=0.
- Bounce: toggle key 9 every frame for 6 frames, then hold -> no event during toggling; exactly one 5'h09 event after 2 stable frames.
- Multi-press and full: press keys 0, 5, 10, 15 together and hold key_ready=0 -> FIFO holds 00,05,0A,0F in order. Then add key 3 -> key 3 stays pending. Pop one -> 5'h03 enters next cycle.
- Press-and-release-while-full: FIFO full, press key 7, release before a pop -> no 5'h07 event ever; key_state[7] returns to 0.
- With KEYPAD_RELEASE_EVENT_EN: press and release key 12 -> events 5'h0C then 5'h1C. Without the macro -> only 5'h0C.
